// File: rtl/tt_um_ripple_count_monitor.sv
// Monitors an asynchronous 3-bit ripple counter. Settled values are captured, wraps are counted
// and any non-+1 step is flagged. The selected value is shown on a seven-segment display.
module tt_um_ripple_count_monitor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] s3;
    logic [2:0] cap;
    logic [2:0] cap_inc;
    logic [7:0] wrap_cnt;
    logic       err;
    logic       capture;
    logic       wrap_evt;
    logic       seq_err;
    logic       clear;
    logic [3:0] disp_nib;
    logic [6:0] seg;
    logic       unused_ok;

    // s2==s3 means the synchronized value held for two cycles, so ripple glitches never capture
    assign cap_inc  = cap + 3'd1;
    assign capture  = ena && (s2 == s3) && (s3 != cap);
    assign wrap_evt = capture && (cap == 3'd7) && (s3 == 3'd0);
    assign seq_err  = capture && (s3 != cap_inc);
    assign clear    = ena && ui_in[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 3'd0;
            s2 <= 3'd0;
            s3 <= 3'd0;
        end else begin
            s1 <= ui_in[2:0];
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap      <= 3'd0;
            wrap_cnt <= 8'd0;
            err      <= 1'b0;
        end else if (ena) begin
            if (capture) begin
                cap <= s3;
            end
            if (clear) begin
                wrap_cnt <= 8'd0;
                err      <= 1'b0;
            end else begin
                if (wrap_evt) begin
                    wrap_cnt <= wrap_cnt + 8'd1;
                end
                if (seq_err) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign disp_nib = ui_in[4] ? wrap_cnt[3:0] : {1'b0, cap};

    always_comb begin
        seg = 7'h00;
        case (disp_nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign uo_out    = {err, seg};
    assign uio_out   = wrap_cnt;
    assign uio_oe    = 8'hFF;
    assign unused_ok = &{1'b0, ui_in[7:5], uio_in};

endmodule

// File: tb/tb_tt_um_ripple_count_monitor.sv
// Directed bench for the ripple count monitor: expected outputs are queued when stimulus is
// applied and popped for comparison once the design has had time to respond.
module tb_tt_um_ripple_count_monitor;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       sel;
    int         n_pass;
    int         n_total;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    tt_um_ripple_count_monitor dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] v, input logic clr);
        ui_in = {3'b000, sel, clr, v};
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_outs(input string tag, input logic [7:0] uo, input logic [7:0] uio);
        push({tag, ".uo_out"}, uo);
        push({tag, ".uio_out"}, uio);
    endtask

    task automatic pop_check(input logic [7:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%02h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.val);
        end
    endtask

    task automatic check_outs();
        pop_check(uo_out);
        pop_check(uio_out);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        sel     = 1'b0;
        rst_n   = 1'b0;
        ena     = 1'b1;
        uio_in  = 8'h00;
        drive(3'd0, 1'b0);

        // outputs during reset, before any clock edge
        #2;
        expect_outs("reset", 8'h3F, 8'h00);
        push("reset.uio_oe", 8'hFF);
        check_outs();
        pop_check(uio_oe);
        hold(2);

        // first capture latency: not yet after 3 edges, present after the 4th
        rst_n = 1'b1;
        drive(3'd1, 1'b0);
        expect_outs("lat_edge3", 8'h3F, 8'h00);
        hold(3);
        check_outs();
        expect_outs("lat_edge4", {1'b0, seg_tab[1]}, 8'h00);
        hold(1);
        check_outs();

        // 1 -> 0 is a skip: err set; then clear it
        drive(3'd0, 1'b0);
        expect_outs("skip_1to0", {1'b1, seg_tab[0]}, 8'h00);
        hold(6);
        check_outs();
        drive(3'd0, 1'b1);
        hold(1);
        drive(3'd0, 1'b0);
        expect_outs("clear_err", {1'b0, seg_tab[0]}, 8'h00);
        hold(1);
        check_outs();

        // full in-order pass 1..7,0 gives exactly one wrap
        for (int v = 1; v <= 8; v++) begin
            drive(3'(v % 8), 1'b0);
            expect_outs($sformatf("step_%0d", v % 8), {1'b0, seg_tab[v % 8]}, (v == 8) ? 8'h01 : 8'h00);
            hold(6);
            check_outs();
        end

        // single-cycle glitch is rejected
        drive(3'd1, 1'b0);
        hold(6);
        drive(3'd2, 1'b0);
        hold(6);
        drive(3'd6, 1'b0);
        hold(1);
        drive(3'd2, 1'b0);
        expect_outs("glitch", {1'b0, seg_tab[2]}, 8'h01);
        hold(6);
        check_outs();

        // 2 -> 5 jump sets err; clear resets err and wrap counter, cap kept
        drive(3'd5, 1'b0);
        expect_outs("jump_2to5", {1'b1, seg_tab[5]}, 8'h01);
        hold(6);
        check_outs();
        drive(3'd5, 1'b1);
        hold(1);
        drive(3'd5, 1'b0);
        expect_outs("clear_after_jump", {1'b0, seg_tab[5]}, 8'h00);
        hold(1);
        check_outs();

        // wrap counter rollover
        for (int w = 1; w <= 258; w++) begin
            for (int k = 6; k <= 13; k++) begin
                drive(3'(k % 8), 1'b0);
                hold(5);
            end
            if (w == 255 || w == 256 || w == 258) begin
                expect_outs($sformatf("wraps_%0d", w), {1'b0, seg_tab[5]}, 8'(w % 256));
                check_outs();
            end
        end

        // display select is combinational
        sel = 1'b1;
        drive(3'd5, 1'b0);
        #1;
        expect_outs("sel_wrap", {1'b0, seg_tab[2]}, 8'h02);
        check_outs();
        sel = 1'b0;
        drive(3'd5, 1'b0);
        #1;
        expect_outs("sel_cap", {1'b0, seg_tab[5]}, 8'h02);
        check_outs();

        // clear on the same edge as a 7 -> 0 wrap capture wins
        drive(3'd6, 1'b0);
        hold(5);
        drive(3'd7, 1'b0);
        hold(5);
        drive(3'd0, 1'b0);
        expect_outs("pre_clear_wrap", {1'b0, seg_tab[7]}, 8'h02);
        hold(3);
        check_outs();
        drive(3'd0, 1'b1);
        expect_outs("clear_vs_wrap", {1'b0, seg_tab[0]}, 8'h00);
        hold(1);
        check_outs();
        drive(3'd0, 1'b0);

        // ena=0 freezes capture and clear; pending change captured on first enabled edge
        drive(3'd1, 1'b0);
        hold(5);
        drive(3'd4, 1'b0);
        expect_outs("err_0to..4", {1'b1, seg_tab[4]}, 8'h00);
        hold(5);
        check_outs();
        ena = 1'b0;
        drive(3'd5, 1'b0);
        expect_outs("ena_freeze", {1'b1, seg_tab[4]}, 8'h00);
        hold(6);
        check_outs();
        drive(3'd5, 1'b1);
        expect_outs("ena_clear_ignored", {1'b1, seg_tab[4]}, 8'h00);
        hold(1);
        check_outs();
        drive(3'd5, 1'b0);
        ena = 1'b1;
        expect_outs("ena_resume", {1'b1, seg_tab[5]}, 8'h00);
        hold(1);
        check_outs();

        // asynchronous reset mid-capture
        drive(3'd3, 1'b0);
        hold(2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_outs("async_reset", 8'h3F, 8'h00);
        push("async_reset.uio_oe", 8'hFF);
        check_outs();
        pop_check(uio_oe);
        hold(2);

        // after release, the held 3 compares against cap=0 and flags an error
        rst_n = 1'b1;
        expect_outs("post_reset_edge3", 8'h3F, 8'h00);
        hold(3);
        check_outs();
        expect_outs("post_reset_capture", {1'b1, seg_tab[3]}, 8'h00);
        hold(1);
        check_outs();

        n_total++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tt_um_ripple_count_monitor.md
TT_UM_RIPPLE_COUNT_MONITOR -- requirements
Module: tt_um_ripple_count_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. The ports SHALL be:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-002 ena  input  1  design enable; 0 freezes the capture register, wrap counter and error flag (synchronizer stages keep running).
REQ-003 ui_in  input  8  inputs:
- [2:0] upstream 3-bit ripple count, asynchronous to clk;
- [3] synchronous clear of the wrap counter and error flag;
- [4] display select (0 = captured count, 1 = wrap counter low nibble);
- [7:5] unused.
REQ-004 uo_out  output  8  outputs:
- [6:0] seven-segment pattern, active high, bit0 = a ... bit6 = g;
- [7] sticky sequence-error flag.
REQ-005 uio_in  input  8  unused.
REQ-006 uio_out  output  8  8-bit wrap counter value.
REQ-007 uio_oe  output  8  constant 8'hFF.

Function
REQ-008 Each bit of ui_in[2:0] SHALL pass through a 2-flop synchronizer (s1, s2), followed by one further delay register s3.
REQ-009 The capture register cap[2:0] SHALL load s3 on a rising edge when all of the following hold at that edge: ena=1, s2==s3, s3!=cap.
- Rationale: rejects ripple-settling glitches shorter than 2 cycles.
REQ-010 Latency: an input that is held stable SHALL appear in cap on the 4th rising edge after it is first sampled into s1.
REQ-011 A capture event SHALL be a wrap when old cap==7 and new value==0.
- On a wrap, wrap_cnt[7:0] SHALL increment by 1 on the same edge.
- 255 SHALL roll over to 0 with no saturation and no flag.
REQ-012 A capture event SHALL set err (uo_out[7]) on the same edge when new value != (old cap + 1) mod 8.
- This covers skips caused by upstream asynchronous set inputs.
- err SHALL be sticky until cleared.
REQ-013 When ui_in[3]=1 and ena=1, wrap_cnt and err SHALL go to 0 on the next edge.
- Clear SHALL take priority over a simultaneous wrap or error event.
- cap SHALL be unaffected by clear.
REQ-014 The segment decode SHALL be combinational from cap (select=0) or wrap_cnt[3:0] (select=1).
- Hex table (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-015 The display select SHALL take effect combinationally, with no added latency.
REQ-016 With ena=0, s1/s2/s3 SHALL keep sampling.
- No capture, wrap or error update SHALL occur.
- A change pending at ena re-assertion SHALL be captured on the first enabled edge where REQ-009 holds.

Reset
REQ-017 rst_n=0 SHALL asynchronously force s1, s2, s3, cap, wrap_cnt and err to 0, with no dependence on clk.
REQ-018 During and after reset, the outputs SHALL be:
- uo_out = 8'h3F (digit 0, err=0);
- uio_out = 8'h00;
- uio_oe = 8'hFF.
REQ-019 Reset asserted mid-capture SHALL discard any pending value.
- After release, the first capture SHALL compare against cap=0.
- Example: input 3 present at release -> err set (0->3 is not +1).
REQ-020 Reset release SHALL be synchronous-safe, so the first enabled edge after release behaves per REQ-009.

Verification
REQ-021 Reset, then drive ui_in[2:0] = 1 at cycle 0 -> cap=1 after edge 4; uo_out[6:0]=06; err=0.
REQ-022 Step the input 0..7..0 with each value held for 6 cycles -> uio_out=01, err=0, and the display tracks 0..7 in order.
REQ-023 Hold the input at 2, glitch to 6 for 1 cycle, then return to 2 -> cap stays 2 and err stays 0.
REQ-024 Jump the input 2->5 -> err=1 after capture; assert ui_in[3] for 1 cycle -> err=0 and uio_out=00.
REQ-025 Perform 256 full wraps -> uio_out=00.
- After 258 wraps with ui_in[4]=1 -> uio_out=02 and uo_out[6:0]=5B.
REQ-026 Apply clear on the same edge a 7->0 capture occurs -> uio_out=00 and err=0.
- Then assert rst_n=0 mid-sequence -> all outputs return to their reset values immediately.
